checker_move_ctrl: RTL and testbench

- Owns the 64-square checkers board state and sequences every change to it: piece selection, move legality, capture, kinging, turn alternation and game-over detection.
- Sits between cursor_control, which supplies the cursor square and select press, and display, which consumes the serialized board and the selected square.
- Replaces the static initial-board assignment in the top level.

---
 rtl/checker_pkg.sv | 36 +++
 rtl/checker_move_rules.sv | 58 +++++
 rtl/checker_move_ctrl.sv | 146 ++++++++++++++
 tb/tb_checker_move_ctrl.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/checker_pkg.sv
// checker_pkg: shared definitions for the checkers move controller.
//   - square encoding: bit2 = occupied, bit1 = red, bit0 = king
//   - FSM state enum for checker_move_ctrl
//   - init_square(): reset contents of a square addressed as {x[2:0], y[2:0]}
package checker_pkg;

    localparam logic [2:0] EMPTY     = 3'b000;
    localparam logic [2:0] RED_MAN   = 3'b110;
    localparam logic [2:0] BLACK_MAN = 3'b100;

    localparam int OCC  = 2;
    localparam int RED  = 1;
    localparam int KING = 0;

    typedef enum logic [2:0] {
        WAIT_PIECE,
        WAIT_DEST,
        CHECK,
        COMMIT,
        OVER
    } state_t;

    // Only dark squares ((x+y) even) carry pieces: red on rows 0..2, black on rows 5..7.
    function automatic logic [2:0] init_square(input logic [5:0] loc);
        logic [2:0] x;
        logic [2:0] y;
        x = loc[5:3];
        y = loc[2:0];
        if (x[0] == y[0]) begin
            if (y <= 3'd2) return RED_MAN;
            if (y >= 3'd5) return BLACK_MAN;
        end
        return EMPTY;
    endfunction

endpackage

// File: rtl/checker_move_rules.sv
// checker_move_rules: combinational legality check for one proposed move.
//   src, dest        : squares {x, y}
//   src_piece        : piece being moved (defines colour and king status)
//   dest_piece       : contents of the destination
//   mid_piece        : contents of mid_loc (only meaningful for a jump)
//   legal            : move is a legal simple move or single jump
//   is_jump          : geometry is a two-square diagonal
//   mid_loc          : square jumped over
//   promote          : mover reaches the far row and becomes a king
module checker_move_rules
    import checker_pkg::*;
(
    input  logic [5:0] src,
    input  logic [5:0] dest,
    input  logic [2:0] src_piece,
    input  logic [2:0] dest_piece,
    input  logic [2:0] mid_piece,
    output logic       legal,
    output logic       is_jump,
    output logic [5:0] mid_loc,
    output logic       promote
);
    localparam logic signed [3:0] P1 = 4'sd1;
    localparam logic signed [3:0] N1 = -4'sd1;
    localparam logic signed [3:0] P2 = 4'sd2;
    localparam logic signed [3:0] N2 = -4'sd2;

    logic signed [3:0] dx, dy;
    logic [3:0] mx, my;
    logic is_red, is_king, fwd_ok, back_ok, step1, step2, mid_enemy;
    logic unused_bits;

    // 4-bit signed so that e.g. 0 - 7 yields -7 rather than wrapping to +1.
    assign dx = $signed({1'b0, dest[5:3]}) - $signed({1'b0, src[5:3]});
    assign dy = $signed({1'b0, dest[2:0]}) - $signed({1'b0, src[2:0]});

    assign mx = {1'b0, src[5:3]} + {1'b0, dest[5:3]};
    assign my = {1'b0, src[2:0]} + {1'b0, dest[2:0]};
    assign mid_loc = {mx[3:1], my[3:1]};
    assign unused_bits = mx[0] ^ my[0] ^ mid_piece[KING];

    assign is_red  = src_piece[RED];
    assign is_king = src_piece[KING];

    // Red advances toward y = 7, black toward y = 0; kings go either way.
    assign fwd_ok  = is_red  ? (dy == P1 || dy == P2) : (dy == N1 || dy == N2);
    assign back_ok = is_king && (is_red ? (dy == N1 || dy == N2) : (dy == P1 || dy == P2));

    assign step1 = (dx == P1 || dx == N1) && (dy == P1 || dy == N1) && (fwd_ok || back_ok);
    assign step2 = (dx == P2 || dx == N2) && (dy == P2 || dy == N2) && (fwd_ok || back_ok);

    assign mid_enemy = mid_piece[OCC] && (mid_piece[RED] != is_red);

    assign is_jump = step2;
    assign legal   = src_piece[OCC] && (dest_piece == EMPTY) && (step1 || (step2 && mid_enemy));
    assign promote = is_red ? (dest[2:0] == 3'd7) : (dest[2:0] == 3'd0);

endmodule

// File: rtl/checker_move_ctrl.sv
// checker_move_ctrl: owns the checkers board and sequences every move.
//   clk, rst (sync, active low)
//   cursor_loc, select   : cursor square {x,y} and debounced select pulse
//   serialized_board     : square i at bits [3i+2:3i]
//   sel_loc, sel_valid   : current selection
//   turn                 : colour to move (1 = red)
//   move_done, move_err  : one-cycle pulses (commit / rejected select)
//   game_over, winner    : sticky end-of-game flag and winning colour
//   red_count, black_count : remaining pieces
module checker_move_ctrl
    import checker_pkg::*;
#(
    parameter logic FIRST_TURN = 1'b1,
    parameter int   CNT_W      = 4
)(
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       cursor_loc,
    input  logic             select,
    output logic [191:0]     serialized_board,
    output logic [5:0]       sel_loc,
    output logic             sel_valid,
    output logic             turn,
    output logic             move_done,
    output logic             move_err,
    output logic             game_over,
    output logic             winner,
    output logic [CNT_W-1:0] red_count,
    output logic [CNT_W-1:0] black_count
);
    logic [63:0][2:0] board;
    state_t           state;
    logic [5:0]       dest_loc, mid_q;
    logic             jump_q, promote_q;

    logic [2:0] cur_piece, src_piece, dest_piece, mid_piece;
    logic       cur_own, legal, is_jump, promote;
    logic [5:0] mid_loc;
    logic       unused_cur_king;

    assign serialized_board = board;
    assign cur_piece  = board[cursor_loc];
    assign src_piece  = board[sel_loc];
    assign dest_piece = board[dest_loc];
    assign mid_piece  = board[mid_loc];
    assign cur_own    = cur_piece[OCC] && (cur_piece[RED] == turn);
    assign unused_cur_king = cur_piece[KING];

    checker_move_rules u_rules (
        .src        (sel_loc),
        .dest       (dest_loc),
        .src_piece  (src_piece),
        .dest_piece (dest_piece),
        .mid_piece  (mid_piece),
        .legal      (legal),
        .is_jump    (is_jump),
        .mid_loc    (mid_loc),
        .promote    (promote)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 64; i++) board[i] <= init_square(6'(i));
            state       <= WAIT_PIECE;
            turn        <= FIRST_TURN;
            sel_valid   <= 1'b0;
            sel_loc     <= 6'd0;
            dest_loc    <= 6'd0;
            mid_q       <= 6'd0;
            jump_q      <= 1'b0;
            promote_q   <= 1'b0;
            move_done   <= 1'b0;
            move_err    <= 1'b0;
            game_over   <= 1'b0;
            winner      <= 1'b0;
            red_count   <= CNT_W'(12);
            black_count <= CNT_W'(12);
        end else begin
            move_done <= 1'b0;
            move_err  <= 1'b0;
            case (state)
                WAIT_PIECE: if (select) begin
                    if (cur_own) begin
                        sel_loc   <= cursor_loc;
                        sel_valid <= 1'b1;
                        state     <= WAIT_DEST;
                    end else begin
                        move_err <= 1'b1;
                    end
                end
                WAIT_DEST: if (select) begin
                    if (cursor_loc == sel_loc) begin
                        sel_valid <= 1'b0;
                        state     <= WAIT_PIECE;
                    end else if (cur_own) begin
                        sel_loc <= cursor_loc;
                    end else begin
                        dest_loc <= cursor_loc;
                        state    <= CHECK;
                    end
                end
                CHECK: begin
                    jump_q    <= is_jump;
                    mid_q     <= mid_loc;
                    promote_q <= promote;
                    if (legal) begin
                        state <= COMMIT;
                    end else begin
                        move_err <= 1'b1;
                        state    <= WAIT_DEST;
                    end
                end
                COMMIT: begin
                    board[dest_loc] <= {src_piece[OCC:RED], src_piece[KING] | promote_q};
                    board[sel_loc]  <= EMPTY;
                    sel_valid       <= 1'b0;
                    turn            <= ~turn;
                    move_done       <= 1'b1;
                    state           <= WAIT_PIECE;
                    if (jump_q) begin
                        board[mid_q] <= EMPTY;
                        // The mover's opponent loses a piece; the last one ends the game.
                        if (turn) begin
                            black_count <= black_count - CNT_W'(1);
                            if (black_count == CNT_W'(1)) begin
                                state     <= OVER;
                                game_over <= 1'b1;
                                winner    <= turn;
                            end
                        end else begin
                            red_count <= red_count - CNT_W'(1);
                            if (red_count == CNT_W'(1)) begin
                                state     <= OVER;
                                game_over <= 1'b1;
                                winner    <= turn;
                            end
                        end
                    end
                end
                OVER:    ;
                default: state <= WAIT_PIECE;
            endcase
        end
    end

endmodule

// File: tb/tb_checker_move_ctrl.sv
module tb_checker_move_ctrl;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [5:0]   cursor_loc = 6'd0;
    logic         select = 1'b0;
    logic [191:0] serialized_board;
    logic [5:0]   sel_loc;
    logic         sel_valid, turn, move_done, move_err, game_over, winner;
    logic [3:0]   red_count, black_count;

    checker_move_ctrl #(.FIRST_TURN(1'b1), .CNT_W(4)) dut (
        .clk              (clk),
        .rst              (rst),
        .cursor_loc       (cursor_loc),
        .select           (select),
        .serialized_board (serialized_board),
        .sel_loc          (sel_loc),
        .sel_valid        (sel_valid),
        .turn             (turn),
        .move_done        (move_done),
        .move_err         (move_err),
        .game_over        (game_over),
        .winner           (winner),
        .red_count        (red_count),
        .black_count      (black_count)
    );

    always #5 clk = ~clk;

    int pass_cnt = 0;
    int tot_cnt  = 0;
    bit chk_en   = 0;

    task automatic chk(input string name, input int act, input int exp);
        tot_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    task automatic chk_board(input logic [191:0] act, input logic [191:0] exp);
        tot_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL board: got %h expected %h (t=%0t)", act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    // Board as plain ints (square = x*8+y), move resolution modelled as a
    // pending phase: 1 = decision edge, 2 = commit edge.
    int mb[64];
    bit m_turn, m_sv, m_done, m_err, m_over, m_win, m_legal;
    int m_sl, m_dest, m_red, m_black, m_phase;

    function automatic int init_sq(int x, int y);
        if ((x + y) % 2 == 0 && y <= 2) return 6;
        if ((x + y) % 2 == 0 && y >= 5) return 4;
        return 0;
    endfunction

    function automatic bit colour(int p);
        return bit'((p >> 1) & 1);
    endfunction

    function automatic bit is_legal(int s, int d);
        int sx, sy, dx, dy, fwd, m, p;
        bit king;
        p = mb[s];
        if (p == 0 || mb[d] != 0) return 0;
        sx = s / 8; sy = s % 8;
        dx = d / 8 - sx; dy = d % 8 - sy;
        fwd = colour(p) ? 1 : -1;
        king = bit'(p & 1);
        if ((dx == 1 || dx == -1) && (dy == fwd || (king && dy == -fwd))) return 1;
        if ((dx == 2 || dx == -2) && (dy == 2 * fwd || (king && dy == -2 * fwd))) begin
            m = (sx + dx / 2) * 8 + (sy + dy / 2);
            return mb[m] != 0 && colour(mb[m]) != colour(p);
        end
        return 0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 64; i++) mb[i] = init_sq(i / 8, i % 8);
        m_turn = 1; m_sv = 0; m_sl = 0; m_dest = 0; m_phase = 0;
        m_over = 0; m_win = 0; m_red = 12; m_black = 12; m_legal = 0;
    endtask

    task automatic model_select(input int c);
        bit own;
        own = mb[c] != 0 && colour(mb[c]) == m_turn;
        if (!m_sv) begin
            if (own) begin m_sl = c; m_sv = 1; end
            else m_err = 1;
        end else if (c == m_sl) m_sv = 0;
        else if (own) m_sl = c;
        else begin
            m_dest = c; m_legal = is_legal(m_sl, c); m_phase = 1;
        end
    endtask

    task automatic model_commit();
        int p, dx;
        bit red;
        p = mb[m_sl];
        red = colour(p);
        dx = m_dest / 8 - m_sl / 8;
        if ((red && m_dest % 8 == 7) || (!red && m_dest % 8 == 0)) p = p | 1;
        mb[m_dest] = p;
        mb[m_sl] = 0;
        if (dx == 2 || dx == -2) begin
            mb[((m_sl / 8 + m_dest / 8) / 2) * 8 + (m_sl % 8 + m_dest % 8) / 2] = 0;
            if (red) m_black--; else m_red--;
        end
        m_done = 1; m_sv = 0;
        if ((red ? m_black : m_red) == 0) begin m_over = 1; m_win = m_turn; end
        m_turn = !m_turn;
    endtask

    always @(posedge clk) begin
        m_done = 0; m_err = 0;
        if (!rst) model_reset();
        else if (!m_over) begin
            if (m_phase == 1) begin
                if (m_legal) m_phase = 2;
                else begin m_err = 1; m_phase = 0; end
            end else if (m_phase == 2) begin
                model_commit();
                m_phase = 0;
            end else if (select) model_select(int'(cursor_loc));
        end
    end

    task automatic compare_all();
        logic [191:0] eb;
        for (int i = 0; i < 64; i++) eb[3*i +: 3] = 3'(mb[i]);
        chk_board(serialized_board, eb);
        chk("sel_valid", int'(sel_valid), int'(m_sv));
        chk("sel_loc", int'(sel_loc), m_sl);
        chk("turn", int'(turn), int'(m_turn));
        chk("move_done", int'(move_done), int'(m_done));
        chk("move_err", int'(move_err), int'(m_err));
        chk("game_over", int'(game_over), int'(m_over));
        if (m_over) chk("winner", int'(winner), int'(m_win));
        chk("red_count", int'(red_count), m_red);
        chk("black_count", int'(black_count), m_black);
        chk("err_done_excl", int'(move_err && move_done), 0);
    endtask

    always @(negedge clk) if (chk_en) compare_all();

    // ---------------- stimulus ----------------
    function automatic int sq(int loc);
        return int'(serialized_board[3*loc +: 3]);
    endfunction

    task automatic press(input int loc);
        @(posedge clk); #2;
        cursor_loc = 6'(loc);
        select = 1'b1;
        @(posedge clk); #2;
        select = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk); #2;
        rst = 1'b0; select = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
    endtask

    task automatic settle(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic pick_move(output int s, output int d);
        int js[$], jd[$], ss[$], sd[$];
        int bx, by, k;
        for (int a = 0; a < 64; a++) begin
            if (mb[a] != 0 && colour(mb[a]) == m_turn) begin
                for (int ddx = -2; ddx <= 2; ddx++)
                    for (int ddy = -2; ddy <= 2; ddy++) begin
                        bx = a / 8 + ddx; by = a % 8 + ddy;
                        if (bx >= 0 && bx < 8 && by >= 0 && by < 8 && is_legal(a, bx * 8 + by)) begin
                            if (ddx == 2 || ddx == -2) begin js.push_back(a); jd.push_back(bx * 8 + by); end
                            else begin ss.push_back(a); sd.push_back(bx * 8 + by); end
                        end
                    end
            end
        end
        s = int'($urandom_range(0, 63));
        d = int'($urandom_range(0, 63));
        if ($urandom_range(0, 7) == 0) return;
        if (js.size() > 0 && $urandom_range(0, 3) != 0) begin
            k = int'($urandom_range(0, js.size() - 1)); s = js[k]; d = jd[k];
        end else if (ss.size() > 0) begin
            k = int'($urandom_range(0, ss.size() - 1)); s = ss[k]; d = sd[k];
        end
    endtask

    initial begin
        int s, d, dones;

        // Reset state
        do_reset();
        chk_en = 1;
        @(negedge clk);
        chk("rst_sq02", sq(6'o02), 6);
        chk("rst_sq15", sq(6'o15), 4);
        chk("rst_sq03", sq(6'o03), 0);
        chk("rst_turn", int'(turn), 1);
        chk("rst_red", int'(red_count), 12);
        chk("rst_black", int'(black_count), 12);
        chk("rst_sel_valid", int'(sel_valid), 0);

        // Wrong colour on red's turn
        press(6'o15);
        @(negedge clk);
        chk("wrong_col_err", int'(move_err), 1);
        chk("wrong_col_sel", int'(sel_valid), 0);

        // Illegal destination (dx = 0): error one edge after the dest select
        press(6'o11);
        press(6'o13);
        settle(1);
        chk("illegal_err", int'(move_err), 1);
        chk("illegal_sel_valid", int'(sel_valid), 1);
        chk("illegal_sel_loc", int'(sel_loc), 6'o11);

        // Deselect then reselect
        press(6'o11);
        press(6'o02);
        press(6'o02);
        @(negedge clk);
        chk("deselect", int'(sel_valid), 0);
        press(6'o02);
        press(6'o22);
        @(negedge clk);
        chk("reselect_loc", int'(sel_loc), 6'o22);
        chk("reselect_valid", int'(sel_valid), 1);
        chk("reselect_noerr", int'(move_err), 0);

        // Simple move 02 -> 13 (reselect 02 first)
        press(6'o02);
        press(6'o13);
        settle(2);
        chk("simple_done", int'(move_done), 1);
        settle(1);
        chk("simple_dest", sq(6'o13), 6);
        chk("simple_src", sq(6'o02), 0);
        chk("simple_turn", int'(turn), 0);

        // Black 35 -> 24, then red jumps 13 -> 35
        press(6'o35);
        press(6'o24);
        settle(3);
        press(6'o13);
        press(6'o35);
        settle(3);
        chk("cap_mid", sq(6'o24), 0);
        chk("cap_dest", sq(6'o35), 6);
        chk("cap_black", int'(black_count), 11);
        chk("cap_turn", int'(turn), 0);

        // Reset while the move is in CHECK
        do_reset();
        press(6'o02);
        press(6'o13);
        rst = 1'b0;
        @(posedge clk); #2;
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_sq02", sq(6'o02), 6);
        chk("midrst_sq13", sq(6'o13), 0);
        chk("midrst_turn", int'(turn), 1);
        chk("midrst_sel", int'(sel_valid), 0);
        dones = 0;
        repeat (4) begin @(negedge clk); if (move_done) dones++; end
        chk("midrst_no_done", dones, 0);

        // Randomized games
        for (int g = 0; g < 6; g++) begin
            do_reset();
            for (int k = 0; k < 300 && !m_over; k++) begin
                pick_move(s, d);
                if (!(m_sv && m_sl == s) || $urandom_range(0, 5) == 0) press(s);
                press(d);
                if ($urandom_range(0, 3) == 0) press(int'($urandom_range(0, 63)));
                repeat (2 + $urandom_range(0, 2)) @(posedge clk);
            end
            repeat (3) press(int'($urandom_range(0, 63)));
        end

        settle(2);
        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule
